// File: rtl/irq_arbiter.sv
// irq_arbiter: round-robin interrupt arbiter with edge-sensitive sources
// and a small GIE/IER/ISR/IAR/IPR/IVR register block.
module irq_arbiter #(
   parameter int NUM_SRC          = 8,
   parameter bit IRQ_ACTIVE_STATE = 1'b1
) (
   input  logic               ACLK,
   input  logic               ARESETN,
   input  logic [NUM_SRC-1:0] src_in,
   input  logic               reg_wr,
   input  logic               reg_rd,
   input  logic [4:0]         reg_addr,
   input  logic [31:0]        reg_wdata,
   output logic [31:0]        reg_rdata,
   output logic               irq,
   output logic [4:0]         irq_vec,
   output logic               irq_vec_valid
);

   typedef enum logic [1:0] {IDLE, ARB, ASSERT, GAP} state_t;

   localparam logic [4:0] LAST_RST = 5'(NUM_SRC - 1);

   state_t             state;
   state_t             state_nxt;
   logic               gie;
   logic               armed;
   logic [NUM_SRC-1:0] ier;
   logic [NUM_SRC-1:0] isr;
   logic [NUM_SRC-1:0] src_prev;
   logic [NUM_SRC-1:0] ipr;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] ack_mask;
   logic [31:0]        ipr32;
   logic [31:0]        rd_mux;
   logic [4:0]         last_grant;
   logic [4:0]         saved_grant;
   logic [4:0]         winner;
   logic               win_found;
   logic [2:0]         word;
   logic               wr_gie;
   logic               wr_ier;
   logic               wr_iar;
   logic               ack_hit;
   logic               drop_grant;
   logic               unused_addr;

   assign word        = reg_addr[4:2];
   assign unused_addr = ^reg_addr[1:0];
   assign wr_gie      = reg_wr && (word == 3'd0);
   assign wr_ier      = reg_wr && (word == 3'd1);
   assign wr_iar      = reg_wr && (word == 3'd3);
   assign ipr         = isr & ier;
   assign ipr32       = 32'(ipr);
   // The first cycle after reset only loads history, so a source
   // already high at release never counts as an edge.
   assign rise        = armed ? (src_in & ~src_prev) : '0;
   assign ack_mask    = wr_iar ? reg_wdata[NUM_SRC-1:0] : '0;
   assign ack_hit     = wr_iar && reg_wdata[irq_vec];
   assign drop_grant  = (wr_gie && !reg_wdata[0]) ||
                        (wr_ier && !reg_wdata[irq_vec]);

   // Control and sticky status registers; a new edge beats a clear.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         gie      <= 1'b0;
         ier      <= '0;
         isr      <= '0;
         src_prev <= '0;
         armed    <= 1'b0;
      end else begin
         armed    <= 1'b1;
         src_prev <= src_in;
         isr      <= (isr & ~ack_mask) | rise;
         if (wr_gie) gie <= reg_wdata[0];
         if (wr_ier) ier <= reg_wdata[NUM_SRC-1:0];
      end
   end

   // Read mux; unmapped words and the write-only ack word read 0.
   always_comb begin
      rd_mux = '0;
      case (word)
         3'd0:    rd_mux = {31'b0, gie};
         3'd1:    rd_mux = 32'(ier);
         3'd2:    rd_mux = 32'(isr);
         3'd4:    rd_mux = ipr32;
         3'd5:    rd_mux = {irq_vec_valid, 26'b0, irq_vec};
         default: rd_mux = '0;
      endcase
   end

   // Read data register, sampled with pre-write register contents.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) reg_rdata <= '0;
      else if (reg_rd) reg_rdata <= rd_mux;
   end

   // Round-robin search upward from the source after last_grant.
   always_comb begin
      logic [5:0] s;
      win_found = 1'b0;
      winner    = '0;
      s         = '0;
      for (int i = 1; i <= NUM_SRC; i++) begin
         s = {1'b0, last_grant} + 6'(i);
         if (s >= 6'(NUM_SRC)) s = s - 6'(NUM_SRC);
         if (!win_found && ipr32[s[4:0]]) begin
            win_found = 1'b1;
            winner    = s[4:0];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) state <= IDLE;
      else state <= state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gie && |ipr) state_nxt = ARB;
         ARB:     state_nxt = (gie && win_found) ? ASSERT : IDLE;
         ASSERT: begin
            if (ack_hit) state_nxt = GAP;
            else if (drop_grant) state_nxt = IDLE;
         end
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM output: irq is active only while a grant is asserted.
   always_comb begin
      irq = ~IRQ_ACTIVE_STATE;
      if (state == ASSERT) irq = IRQ_ACTIVE_STATE;
   end

   // Grant bookkeeping; a discarded grant restores the old pointer.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         irq_vec       <= '0;
         irq_vec_valid <= 1'b0;
         last_grant    <= LAST_RST;
         saved_grant   <= LAST_RST;
      end else if (state == ARB && state_nxt == ASSERT) begin
         irq_vec       <= winner;
         irq_vec_valid <= 1'b1;
         saved_grant   <= last_grant;
         last_grant    <= winner;
      end else if (state == ASSERT && state_nxt != ASSERT) begin
         irq_vec       <= '0;
         irq_vec_valid <= 1'b0;
         if (state_nxt == IDLE) last_grant <= saved_grant;
      end
   end

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed and random stimulus for irq_arbiter,
// checked against a cycle-level behavioural model.
module tb_irq_arbiter;

   localparam int N = 8;

   logic          ACLK = 1'b0;
   logic          ARESETN = 1'b0;
   logic [N-1:0]  src_in = '0;
   logic          reg_wr = 1'b0;
   logic          reg_rd = 1'b0;
   logic [4:0]    reg_addr = '0;
   logic [31:0]   reg_wdata = '0;
   logic [31:0]   rdata_hi, rdata_lo;
   logic          irq_hi, irq_lo;
   logic [4:0]    vec_hi, vec_lo;
   logic          vv_hi, vv_lo;

   int n_chk = 0;
   int n_err = 0;

   always #5 ACLK = ~ACLK;

   irq_arbiter #(.NUM_SRC(N), .IRQ_ACTIVE_STATE(1'b1)) dut_hi (
      .ACLK(ACLK), .ARESETN(ARESETN), .src_in(src_in),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(rdata_hi), .irq(irq_hi),
      .irq_vec(vec_hi), .irq_vec_valid(vv_hi)
   );

   irq_arbiter #(.NUM_SRC(N), .IRQ_ACTIVE_STATE(1'b0)) dut_lo (
      .ACLK(ACLK), .ARESETN(ARESETN), .src_in(src_in),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(rdata_lo), .irq(irq_lo),
      .irq_vec(vec_lo), .irq_vec_valid(vv_lo)
   );

   // reference model state
   bit         m_gie, m_armed, m_gap, m_arb;
   bit [N-1:0] m_ier, m_isr, m_prev;
   int         m_last, m_saved, m_grant;
   bit [31:0]  m_rdata;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_gie = 0; m_armed = 0; m_gap = 0; m_arb = 0;
      m_ier = '0; m_isr = '0; m_prev = '0;
      m_last = N - 1; m_saved = N - 1; m_grant = -1;
      m_rdata = '0;
   endtask

   function automatic int pick(bit [N-1:0] p, int last);
      for (int k = 1; k <= N; k++)
         if (p[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic bit [31:0] peek(int a);
      case (a)
         0: return {31'b0, m_gie};
         1: return 32'(m_ier);
         2: return 32'(m_isr);
         4: return 32'(m_isr & m_ier);
         5: return (m_grant >= 0) ? (32'h8000_0000 | 32'(m_grant)) : 32'h0;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_step();
      int a, w;
      bit [4:0] g;
      bit [N-1:0] ipr, rise, clr;
      a = int'(reg_addr[4:2]);
      ipr = m_isr & m_ier;
      if (reg_rd) m_rdata = peek(a);
      if (m_grant >= 0) begin
         g = m_grant[4:0];
         if (reg_wr && a == 3 && reg_wdata[g]) begin
            m_grant = -1; m_gap = 1;
         end else if (reg_wr && ((a == 0 && !reg_wdata[0]) ||
                                 (a == 1 && !reg_wdata[g]))) begin
            m_grant = -1; m_last = m_saved;
         end
      end else if (m_gap) begin
         m_gap = 0;
      end else if (m_arb) begin
         m_arb = 0;
         w = pick(ipr, m_last);
         if (m_gie && w >= 0) begin
            m_saved = m_last; m_last = w; m_grant = w;
         end
      end else if (m_gie && ipr != '0) begin
         m_arb = 1;
      end
      rise = m_armed ? (src_in & ~m_prev) : '0;
      clr = (reg_wr && a == 3) ? reg_wdata[N-1:0] : '0;
      m_isr = (m_isr & ~clr) | rise;
      if (reg_wr && a == 0) m_gie = reg_wdata[0];
      if (reg_wr && a == 1) m_ier = reg_wdata[N-1:0];
      m_prev = src_in;
      m_armed = 1;
   endtask

   task automatic compare(string tag);
      bit act;
      act = (m_grant >= 0);
      check({tag, ".irq"}, 32'(irq_hi), 32'(act));
      check({tag, ".irq_lo"}, 32'(irq_lo), 32'(!act));
      check({tag, ".vec"}, 32'(vec_hi), act ? 32'(m_grant) : 32'h0);
      check({tag, ".vv"}, 32'(vv_hi), 32'(act));
      check({tag, ".rdata"}, rdata_hi, m_rdata);
      check({tag, ".rdata_lo"}, rdata_lo, m_rdata);
   endtask

   task automatic step(string tag);
      @(posedge ACLK);
      model_step();
      @(negedge ACLK);
      compare(tag);
   endtask

   task automatic run(int n);
      repeat (n) step("run");
   endtask

   task automatic wr(int a, logic [31:0] d);
      reg_wr = 1'b1; reg_addr = 5'(a * 4); reg_wdata = d;
      step("wr");
      reg_wr = 1'b0;
   endtask

   task automatic rd(int a);
      reg_rd = 1'b1; reg_addr = 5'(a * 4);
      step("rd");
      reg_rd = 1'b0;
   endtask

   task automatic pulse(logic [N-1:0] s);
      src_in = s;
      step("pulse");
      src_in = '0;
   endtask

   initial begin
      int op;
      model_reset();
      @(negedge ACLK);
      compare("reset");
      ARESETN = 1'b1;

      // single source, latency and register view
      wr(0, 1); wr(1, 1);
      pulse(8'h01);
      run(1);
      check("lat2", 32'(irq_hi), 32'h0);
      run(1);
      check("lat3", 32'(irq_hi), 32'h1);
      rd(5); check("ivr", rdata_hi, 32'h8000_0000);
      rd(4); check("ipr", rdata_hi, 32'h1);
      wr(3, 1); check("ack_irq", 32'(irq_hi), 32'h0);
      rd(4); check("ipr_clr", rdata_hi, 32'h0);

      // two sources, round-robin with gap
      wr(1, 32'hFF);
      pulse(8'h0A); run(2);
      check("rr_first", 32'(vec_hi), 32'd1);
      wr(3, 2); check("gap", 32'(irq_hi), 32'h0);
      run(2);
      check("gap_idle", 32'(irq_hi), 32'h0);
      run(1);
      check("rr_second", 32'(vec_hi), 32'd3);
      wr(3, 8); run(2);

      // wrap from index 7
      pulse(8'h80); run(2);
      check("g7", 32'(vec_hi), 32'd7);
      wr(3, 32'h80); run(2);
      pulse(8'h81); run(2);
      check("wrap0", 32'(vec_hi), 32'd0);
      wr(3, 1); run(3);
      check("wrap7", 32'(vec_hi), 32'd7);
      wr(3, 32'h80); run(2);

      // grant discarded by GIE=0, then regranted
      pulse(8'h04); run(2);
      check("g2", 32'(vec_hi), 32'd2);
      wr(0, 0); check("drop_irq", 32'(irq_hi), 32'h0);
      rd(2); check("isr2_kept", 32'(rdata_hi[2]), 32'h1);
      wr(0, 1); run(2);
      check("regrant2", 32'(vec_hi), 32'd2);
      wr(3, 4); run(2);

      // edge coincides with its own clear: set wins
      src_in = 8'h10;
      wr(3, 32'h10);
      src_in = '0;
      rd(2); check("set_wins", 32'(rdata_hi[4]), 32'h1);
      run(1); wr(3, 32'h10); run(2);

      // reset mid-grant, source high across release
      pulse(8'h01); run(2);
      check("pre_rst_lo", 32'(irq_lo), 32'h0);
      #2 ARESETN = 1'b0;
      model_reset();
      #1;
      check("rst_async_lo", 32'(irq_lo), 32'h1);
      check("rst_async_hi", 32'(irq_hi), 32'h0);
      check("rst_async_vv", 32'(vv_lo), 32'h0);
      src_in = 8'h20;
      @(negedge ACLK);
      ARESETN = 1'b1;
      run(2);
      for (int a = 0; a < 6; a++) begin
         rd(a);
         check("post_rst_reg", rdata_lo, 32'h0);
      end
      src_in = '0;

      // randomized traffic
      wr(0, 1); wr(1, 32'hFF);
      for (int c = 0; c < 2500; c++) begin
         if ($urandom_range(0, 3) == 0)
            src_in = src_in ^ (N'($urandom) & N'($urandom));
         op = $urandom_range(0, 9);
         reg_addr = '0; reg_wdata = $urandom;
         case (op)
            0, 1, 2: begin
               reg_wr = 1'b1; reg_addr = 5'd12;
               if (m_grant >= 0) reg_wdata = 32'(1) << m_grant;
            end
            3: begin reg_wr = 1'b1; reg_addr = 5'd12; end
            4: begin
               reg_wr = 1'b1; reg_addr = 5'd4;
               reg_wdata = $urandom | $urandom;
            end
            5: begin
               reg_wr = 1'b1; reg_addr = 5'd0;
               reg_wdata = 32'($urandom_range(0, 3) != 0);
            end
            6, 7: begin
               reg_rd = 1'b1;
               reg_addr = 5'($urandom_range(0, 31));
            end
            8: begin
               reg_rd = 1'b1; reg_wr = 1'b1; reg_addr = 5'd4;
               reg_wdata = $urandom | $urandom;
            end
            default: ;
         endcase
         step("rnd");
         reg_wr = 1'b0; reg_rd = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
